regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_bypass.sv | 33 +++
 rtl/regfile_mp.sv | 138 +++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   state_t                 : controller state (INIT clears the array, RUN serves traffic)
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for regfile_mp.
//   wr_en/wr_addr/wr_data : NUM_WR packed write ports (port k at slice k)
//   rd_en/rd_addr         : NUM_RD packed read requests
//   rd_data/rd_busy       : combinational read data and scoreboard flags
//   sb_set_en/sb_set_addr : mark one register as having a pending producer
//   init_done             : high once the clear sequence has completed
//   master drives requests, slave (the register file) drives responses.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) ();

  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     init_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, init_done
  );

endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: write-to-read forwarding match for one read port.
//   wr_en/wr_addr/wr_data : all write ports, packed
//   rd_addr               : address of this read port
//   hit                   : some enabled write targets rd_addr this cycle
//   hit_data              : data of the highest-index matching write port
module regfile_bypass
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        hit_data
);

  // Ascending scan so the highest-index match is the last one assigned.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr)) begin
        hit      = 1'b1;
        hit_data = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and a busy scoreboard.
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset; restarts the clear sequence
//   bus : regfile_mp_if slave (write ports, read ports, scoreboard set, init_done)
// After reset the array is cleared one entry per cycle (DEPTH cycles), then
// init_done rises and traffic is served. Entries have no parallel reset so
// the array can map to distributed RAM.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_INIT | clearing entry init_cnt; traffic ignored, reads return 0
//   ST_RUN  | writes, reads, bypass and scoreboard active
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic run_en;
  logic clr_en;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [NUM_WR-1:0] wr_en_g;
  logic [NUM_RD-1:0] hit;
  logic [DATA_W-1:0] hit_data [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (init_cnt == LAST_IDX) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // run_en also drops while rst is high so a reset arriving in RUN blocks
  // that cycle's writes and forces the read outputs to zero.
  always_comb begin
    run_en        = 1'b0;
    clr_en        = 1'b0;
    bus.init_done = 1'b0;
    case (state)
      ST_INIT: clr_en = 1'b1;
      ST_RUN: begin
        run_en        = !rst;
        bus.init_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state == ST_RUN) init_cnt <= '0;
    else                        init_cnt <= init_cnt + ADDR_W'(1);
  end

  // Ascending port order: the highest-index port lands last and wins.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[init_cnt] <= '0;
    end else if (run_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && !(ZERO_REG && bus.wr_addr[k*ADDR_W +: ADDR_W] == '0))
          mem[bus.wr_addr[k*ADDR_W +: ADDR_W]] <= bus.wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Clears first, set last, so a same-cycle set overrides a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (run_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k]) busy[bus.wr_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (bus.sb_set_en && !(ZERO_REG && bus.sb_set_addr == '0))
        busy[bus.sb_set_addr] <= 1'b1;
    end
  end

  assign wr_en_g = bus.wr_en & {NUM_WR{run_en}};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
    regfile_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_byp (
      .wr_en    (wr_en_g),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_addr  (bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .hit      (hit[p]),
      .hit_data (hit_data[p])
    );
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra        = '0;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (run_en && bus.rd_en[p] && !(ZERO_REG && ra == '0)) begin
        rd_data_c[p*DATA_W +: DATA_W] = hit[p] ? hit_data[p] : mem[ra];
        rd_busy_c[p]                  = busy[ra] & ~hit[p];
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule
